// File: rtl/mux2_stream.sv
// mux2_stream: merges two valid/ready streams (a0, a1) into one registered
// output stream y, tagging each word with its source.
// Tie arbitration is selected at build time by MUX2_STREAM_RR_EN:
//   defined   -> round-robin (grant = ~last on a tie)
//   undefined -> fixed priority (a0 wins every tie)
module mux2_stream #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a0_data,
  input  logic             a0_valid,
  output logic             a0_ready,
  input  logic [WIDTH-1:0] a1_data,
  input  logic             a1_valid,
  output logic             a1_ready,
  output logic [WIDTH-1:0] y_data,
  output logic             y_valid,
  input  logic             y_ready,
  output logic             y_src
);

  logic [WIDTH-1:0] y_data_q, y_data_d;
  logic             y_valid_q, y_valid_d;
  logic             y_src_q, y_src_d;
  logic             last_q, last_d;

  logic load;     // output register can accept a word this cycle
  logic req_any;  // at least one requester
  logic gnt_sel;  // granted source when req_any
  logic take;     // an input transfer happens this cycle

  assign load    = ~y_valid_q | y_ready;
  assign req_any = a0_valid | a1_valid;

  // Grant select: a lone requester wins; a tie is resolved by the build mode.
  always_comb begin
    gnt_sel = a1_valid;
    if (a0_valid && a1_valid) begin
`ifdef MUX2_STREAM_RR_EN
      gnt_sel = ~last_q;
`else
      gnt_sel = 1'b0;
`endif
    end
  end

  // Readys are forced low while reset is held, even though load is high then.
  assign take     = load & req_any & rst_n;
  assign a0_ready = take & ~gnt_sel;
  assign a1_ready = take &  gnt_sel;

  // Next state of the output register: load on transfer, empty on drain only.
  always_comb begin
    y_data_d  = y_data_q;
    y_valid_d = y_valid_q;
    y_src_d   = y_src_q;
    last_d    = last_q;
    if (take) begin
      y_data_d  = gnt_sel ? a1_data : a0_data;
      y_src_d   = gnt_sel;
      y_valid_d = 1'b1;
      last_d    = gnt_sel;
    end else if (y_ready) begin
      y_valid_d = 1'b0;
    end
  end

  // State registers; last resets to 1 so a0 wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_data_q  <= '0;
      y_valid_q <= 1'b0;
      y_src_q   <= 1'b0;
      last_q    <= 1'b1;
    end else begin
      y_data_q  <= y_data_d;
      y_valid_q <= y_valid_d;
      y_src_q   <= y_src_d;
      last_q    <= last_d;
    end
  end

  assign y_data  = y_data_q;
  assign y_valid = y_valid_q;
  assign y_src   = y_src_q;

endmodule

// File: tb/tb_mux2_stream.sv
// tb_mux2_stream: directed and randomized checks of mux2_stream against a
// cycle-level reference model plus per-source ordering scoreboards.
// Tie expectations follow MUX2_STREAM_RR_EN.
module tb_mux2_stream;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] a0_data, a1_data, y_data;
  logic         a0_valid, a0_ready, a1_valid, a1_ready;
  logic         y_valid, y_ready, y_src;

  int n_chk = 0;
  int n_err = 0;

  // per-source pending words, accepted-but-not-yet-output words, output log
  logic [W-1:0] q0[$], q1[$], sb0[$], sb1[$], olog[$];

  // reference model of the output register and tie history
  logic         m_valid, m_src, m_last;
  logic [W-1:0] m_data;
  logic         acc0, acc1;

  mux2_stream #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .a0_data(a0_data), .a0_valid(a0_valid), .a0_ready(a0_ready),
    .a1_data(a1_data), .a1_valid(a1_valid), .a1_ready(a1_ready),
    .y_data(y_data), .y_valid(y_valid), .y_ready(y_ready), .y_src(y_src)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_valid = 1'b0; m_data = '0; m_src = 1'b0; m_last = 1'b1;
  endtask

  // present the head of each source queue; valid holds until accepted
  task automatic drive();
    a0_valid = (q0.size() != 0);
    a0_data  = (q0.size() != 0) ? q0[0] : '0;
    a1_valid = (q1.size() != 0);
    a1_data  = (q1.size() != 0) ? q1[0] : '0;
  endtask

  // one clock: check at negedge, advance model, then update drivers after posedge
  task automatic step();
    logic e_load, e_take, e_g;
    logic [W-1:0] exp_w;
    @(negedge clk);
    e_load = !m_valid || y_ready;
    e_take = e_load && (a0_valid || a1_valid);
    if (a0_valid && a1_valid) begin
`ifdef MUX2_STREAM_RR_EN
      e_g = !m_last;
`else
      e_g = 1'b0;
`endif
    end else begin
      e_g = a1_valid;
    end
    chk("a0_ready", a0_ready, e_take && !e_g);
    chk("a1_ready", a1_ready, e_take && e_g);
    chk("y_valid", y_valid, m_valid);
    chk("y_data", y_data, m_data);
    chk("y_src", y_src, m_src);
    // scoreboard: output words must leave in per-source order
    if (y_valid && y_ready) begin
      olog.push_back(y_data);
      if (y_src) begin
        chk("sb1_nonempty", sb1.size() != 0, 1);
        if (sb1.size() != 0) begin exp_w = sb1.pop_front(); chk("sb1_order", y_data, exp_w); end
      end else begin
        chk("sb0_nonempty", sb0.size() != 0, 1);
        if (sb0.size() != 0) begin exp_w = sb0.pop_front(); chk("sb0_order", y_data, exp_w); end
      end
    end
    acc0 = a0_valid && a0_ready;
    acc1 = a1_valid && a1_ready;
    if (acc0) sb0.push_back(a0_data);
    if (acc1) sb1.push_back(a1_data);
    if (e_take) begin
      m_data  = e_g ? a1_data : a0_data;
      m_src   = e_g;
      m_valid = 1'b1;
      m_last  = e_g;
    end else if (y_ready) begin
      m_valid = 1'b0;
    end
    @(posedge clk);
    #1;
    if (acc0) void'(q0.pop_front());
    if (acc1) void'(q1.pop_front());
    drive();
  endtask

  logic [W-1:0] exp_tie[8];
  logic [W-1:0] last_w;
  int           guard;

  initial begin
    model_reset();
    y_ready = 1'b0;
    rst_n   = 1'b0;
    a0_valid = 1'b1; a0_data = 8'h12;
    a1_valid = 1'b1; a1_data = 8'h34;
    #12;
    // reset state: readys held low despite both valids
    chk("rst_y_valid", y_valid, 0);
    chk("rst_y_data", y_data, 0);
    chk("rst_y_src", y_src, 0);
    chk("rst_a0_ready", a0_ready, 0);
    chk("rst_a1_ready", a1_ready, 0);
    drive();
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // single source on a0, then a1
    y_ready = 1'b1;
    q0.push_back(8'h3C); drive();
    step();
    chk("single0_valid", y_valid, 1);
    chk("single0_data", y_data, 8'h3C);
    chk("single0_src", y_src, 0);
    q1.push_back(8'hA5); drive();
    step();
    chk("single1_valid", y_valid, 1);
    chk("single1_data", y_data, 8'hA5);
    chk("single1_src", y_src, 1);

    // async reset mid-cycle while full and a0 requesting
    y_ready = 1'b0;
    q0.push_back(8'h99); drive();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_y_valid", y_valid, 0);
    chk("arst_y_data", y_data, 0);
    chk("arst_y_src", y_src, 0);
    chk("arst_a0_ready", a0_ready, 0);
    chk("arst_a1_ready", a1_ready, 0);
    q0.delete(); q1.delete(); sb0.delete(); sb1.delete();
    drive(); model_reset();
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // tie: both sources with 4 words each
`ifdef MUX2_STREAM_RR_EN
    exp_tie = '{8'h01, 8'h11, 8'h02, 8'h12, 8'h03, 8'h13, 8'h04, 8'h14};
`else
    exp_tie = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h11, 8'h12, 8'h13, 8'h14};
`endif
    olog.delete();
    y_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      q0.push_back(W'(8'h01 + i));
      q1.push_back(W'(8'h11 + i));
    end
    drive();
    for (int i = 0; i < 8; i++) begin
      step();
      chk("tie_y_valid", y_valid, 1);
    end
    step();
    chk("tie_count", olog.size(), 8);
    for (int i = 0; i < 8 && i < olog.size(); i++) chk($sformatf("tie_word%0d", i), olog[i], exp_tie[i]);

    // stall with 8'h55 held, then release
    q0.push_back(8'h55); drive();
    step();
    chk("stall_load", y_data, 8'h55);
    y_ready = 1'b0;
    q0.push_back(8'h66); q1.push_back(8'h77); drive();
    olog.delete();
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_data", y_data, 8'h55);
      chk("stall_src", y_src, 0);
      chk("stall_a0_ready", a0_ready, 0);
      chk("stall_a1_ready", a1_ready, 0);
    end
    y_ready = 1'b1;
    step();
    step();
    last_w = y_data;
    // drain-only: register empties, data keeps its value
    step();
    chk("drain_valid", y_valid, 0);
    chk("drain_data", y_data, last_w);
    step();
    chk("drain_hold", y_data, last_w);
    chk("stall_count", olog.size(), 3);
    if (olog.size() == 3) begin
      chk("stall_first", olog[0], 8'h55);
`ifdef MUX2_STREAM_RR_EN
      chk("stall_second", olog[1], 8'h77);
      chk("stall_third", olog[2], 8'h66);
`else
      chk("stall_second", olog[1], 8'h66);
      chk("stall_third", olog[2], 8'h77);
`endif
    end

    // randomized traffic with random backpressure
    for (int c = 0; c < 2000; c++) begin
      if (q0.size() < 4 && $urandom_range(0, 2) == 0) q0.push_back(W'($urandom));
      if (q1.size() < 4 && $urandom_range(0, 2) == 0) q1.push_back(W'($urandom));
      y_ready = ($urandom_range(0, 3) != 0);
      drive();
      step();
    end

    // final drain, bounded
    y_ready = 1'b1;
    guard = 0;
    while ((q0.size() != 0 || q1.size() != 0 || y_valid) && guard < 100) begin
      step();
      guard++;
    end
    chk("final_drain_done", guard < 100, 1);
    chk("final_sb0_empty", sb0.size(), 0);
    chk("final_sb1_empty", sb1.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
